// File: rtl/cnn_pkg.sv
// Shared types and constants for the convolution MAC / pooling stage.
// Holds the FSM state enum, command bit positions and default sizes.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        MAX,
        OUT
    } state_t;

    localparam int CMD_POOL     = 7;
    localparam int CMD_RELU     = 6;
    localparam int CMD_SHIFT_HI = 3;
    localparam int CMD_SHIFT_LO = 0;

    localparam int DEF_ACC_W = 24;
    localparam int DEF_KTAPS = 9;

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane: bias load or acc += {0,pix} * weight.
// Ports: clk, reset (sync, high), load, mac, bias, pix, weight -> acc.
module mac_lane
    import cnn_pkg::*;
#(
    parameter int ACC_W      = DEF_ACC_W,
    parameter int BIAS_SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    mac,
    input  logic [7:0]              bias,
    input  logic [7:0]              pix,
    input  logic [7:0]              weight,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] bias_x;

    // Pixel is unsigned: zero-extend it, sign-extend the weight.
    assign prod = $signed({9'd0, pix}) *
                  $signed({{9{weight[7]}}, weight});

    assign prod_x = {{(ACC_W-17){prod[16]}}, prod};
    assign bias_x = {{(ACC_W-8){bias[7]}}, bias} <<< BIAS_SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= bias_x;
        end else if (mac) begin
            acc <= acc + prod_x;
        end
    end

endmodule

// File: rtl/conv_mac_pool.sv
// Four-lane conv MAC with optional 2x2 max-pool, ReLU, shift and saturation.
// Inputs: clk, reset, in_valid/first/last, in_p0..3, in_param, addr_clr.
// Outputs: in_ready, res_valid, res_data, res_addr, err (sticky).
// Option macro CONV_MAC_POOL_ROUND_EN: round half up before the shift.
module conv_mac_pool
    import cnn_pkg::*;
#(
    parameter int KTAPS      = DEF_KTAPS,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int BIAS_SHIFT = 0,
    parameter int OUT_DEPTH  = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_first,
    input  logic        in_last,
    input  logic [7:0]  in_p0,
    input  logic [7:0]  in_p1,
    input  logic [7:0]  in_p2,
    input  logic [7:0]  in_p3,
    input  logic [7:0]  in_param,
    input  logic        addr_clr,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic [15:0] res_addr,
    output logic        err
);

    localparam int          TW        = 8;
    localparam logic [15:0] ADDR_LAST = 16'(OUT_DEPTH - 1);

    localparam logic signed [ACC_W:0] Q_U8_HI = 255;
    localparam logic signed [ACC_W:0] Q_S8_HI = 127;
    localparam logic signed [ACC_W:0] Q_S8_LO = -128;

    state_t                  state;
    logic [TW-1:0]           tap_cnt;
    logic                    pool_en;
    logic                    relu_en;
    logic [3:0]              shift;
    logic [1:0]              rem;
    logic                    accept;
    logic                    load;
    logic                    mac;
    logic [7:0]              pix [4];
    logic signed [ACC_W-1:0] acc [4];
    logic signed [ACC_W-1:0] hold [3];
    logic signed [ACC_W-1:0] acc_max;

    assign in_ready = (state == IDLE) || (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign load     = accept && in_first;
    assign mac      = accept && (state == ACCUM) && !in_first && !in_last;

    assign pix[0] = in_p0;
    assign pix[1] = in_p1;
    assign pix[2] = in_p2;
    assign pix[3] = in_p3;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        mac_lane #(
            .ACC_W      (ACC_W),
            .BIAS_SHIFT (BIAS_SHIFT)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .mac    (mac),
            .bias   (in_param),
            .pix    (pix[i]),
            .weight (in_param),
            .acc    (acc[i])
        );
    end

    always_comb begin
        acc_max = acc[0];
        for (int i = 1; i < 4; i++) begin
            if (acc[i] > acc_max) begin
                acc_max = acc[i];
            end
        end
    end

    // Requantise one accumulator to a byte; one guard bit absorbs rounding.
    function automatic logic [7:0] quant(
        input logic signed [ACC_W-1:0] a,
        input logic [3:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W:0] x;
`ifdef CONV_MAC_POOL_ROUND_EN
        logic signed [ACC_W:0] half;
`endif
        x = {a[ACC_W-1], a};
`ifdef CONV_MAC_POOL_ROUND_EN
        half = '0;
        if (sh != 4'd0) begin
            half[sh - 4'd1] = 1'b1;
        end
        x = x + half;
`endif
        x = x >>> sh;
        if (relu) begin
            if (x < 0) begin
                quant = 8'h00;
            end else if (x > Q_U8_HI) begin
                quant = 8'hFF;
            end else begin
                quant = x[7:0];
            end
        end else begin
            if (x < Q_S8_LO) begin
                quant = 8'h80;
            end else if (x > Q_S8_HI) begin
                quant = 8'h7F;
            end else begin
                quant = x[7:0];
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            pool_en   <= 1'b0;
            relu_en   <= 1'b0;
            shift     <= '0;
            rem       <= '0;
            hold      <= '{default: '0};
            res_valid <= 1'b0;
            res_data  <= '0;
            res_addr  <= '0;
            err       <= 1'b0;
        end else begin
            if (addr_clr) begin
                res_addr <= '0;
            end else if (res_valid) begin
                res_addr <= (res_addr == ADDR_LAST) ? 16'd0
                                                    : res_addr + 16'd1;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_first) begin
                            tap_cnt <= '0;
                            state   <= ACCUM;
                            if (in_last) begin
                                err <= 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (in_first) begin
                            // Restart from the new bias; window was broken.
                            tap_cnt <= '0;
                            err     <= 1'b1;
                        end else if (in_last) begin
                            pool_en <= in_p0[CMD_POOL];
                            relu_en <= in_p0[CMD_RELU];
                            shift   <= in_p0[CMD_SHIFT_HI:CMD_SHIFT_LO];
                            state   <= MAX;
                            if (tap_cnt != TW'(KTAPS)) begin
                                err <= 1'b1;
                            end
                        end else if (tap_cnt != '1) begin
                            // Saturate so an overlong window never aliases.
                            tap_cnt <= tap_cnt + 1'b1;
                        end
                    end
                end
                MAX: begin
                    res_valid <= 1'b1;
                    res_data  <= quant(pool_en ? acc_max : acc[0],
                                       shift, relu_en);
                    hold[0]   <= acc[1];
                    hold[1]   <= acc[2];
                    hold[2]   <= acc[3];
                    rem       <= pool_en ? 2'd0 : 2'd3;
                    state     <= OUT;
                end
                OUT: begin
                    if (rem != 2'd0) begin
                        res_data <= quant(hold[0], shift, relu_en);
                        hold[0]  <= hold[1];
                        hold[1]  <= hold[2];
                        rem      <= rem - 2'd1;
                    end else begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_pool.sv
// Directed bench for conv_mac_pool with hand-computed expected results.
// A second instance with OUT_DEPTH=4 shares stimulus to exercise wrap.
module tb_conv_mac_pool;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_p0 = '0;
    logic [7:0]  in_p1 = '0;
    logic [7:0]  in_p2 = '0;
    logic [7:0]  in_p3 = '0;
    logic [7:0]  in_param = '0;
    logic        addr_clr = 1'b0;
    logic        in_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [15:0] res_addr;
    logic        err;
    logic        rdy4;
    logic        val4;
    logic [7:0]  dat4;
    logic [15:0] addr4;
    logic        err4;

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] ea = '0;
    logic [15:0] ea4 = '0;
    logic [7:0]  exp_q;

    always #5 clk = ~clk;

    conv_mac_pool u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_p0     (in_p0),
        .in_p1     (in_p1),
        .in_p2     (in_p2),
        .in_p3     (in_p3),
        .in_param  (in_param),
        .addr_clr  (addr_clr),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_addr  (res_addr),
        .err       (err)
    );

    conv_mac_pool #(.OUT_DEPTH(4)) u_d4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (rdy4),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_p0     (in_p0),
        .in_p1     (in_p1),
        .in_p2     (in_p2),
        .in_p3     (in_p3),
        .in_param  (in_param),
        .addr_clr  (addr_clr),
        .res_valid (val4),
        .res_data  (dat4),
        .res_addr  (addr4),
        .err       (err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        ea    = '0;
        ea4   = '0;
    endtask

    task automatic beat(input logic f, input logic l,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d,
                        input logic [7:0] par);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_p0    = a;
        in_p1    = b;
        in_p2    = c;
        in_p3    = d;
        in_param = par;
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic window(input logic [7:0] bias, input logic [7:0] w,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input int taps, input logic [7:0] cmd);
        beat(1'b1, 1'b0, a, b, c, d, bias);
        for (int k = 0; k < taps; k++) begin
            beat(1'b0, 1'b0, a, b, c, d, w);
        end
        beat(1'b0, 1'b1, cmd, b, c, d, 8'h00);
    endtask

    task automatic adv_addr(input logic clr);
        ea  = clr ? 16'd0 : ea + 16'd1;
        ea4 = clr ? 16'd0 : ((ea4 == 16'd3) ? 16'd0 : ea4 + 16'd1);
    endtask

    // Called in the MAX cycle, one cycle after the command beat.
    task automatic pooled(input string tag, input logic [7:0] d,
                          input logic e, input logic clr);
        chk({tag, "_max_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_max_ready"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_data"}, 32'(res_data), 32'(d));
        chk({tag, "_addr"}, 32'(res_addr), 32'(ea));
        chk({tag, "_addr4"}, 32'(addr4), 32'(ea4));
        chk({tag, "_err"}, 32'(err), 32'(e));
        addr_clr = clr;
        step();
        addr_clr = 1'b0;
        adv_addr(clr);
        chk({tag, "_end_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_end_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_next_addr"}, 32'(res_addr), 32'(ea));
    endtask

    task automatic unpooled(input string tag,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] dv [4];
        dv[0] = d0;
        dv[1] = d1;
        dv[2] = d2;
        dv[3] = d3;
        chk({tag, "_max_valid"}, 32'(res_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("%s_valid%0d", tag, k), 32'(res_valid), 32'd1);
            chk($sformatf("%s_data%0d", tag, k), 32'(res_data), 32'(dv[k]));
            chk($sformatf("%s_addr%0d", tag, k), 32'(res_addr), 32'(ea));
            chk($sformatf("%s_ready%0d", tag, k), 32'(in_ready), 32'd0);
            adv_addr(1'b0);
        end
        step();
        chk({tag, "_end_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_end_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        do_reset();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_addr", 32'(res_addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // 5 + 9*p : lanes 14,23,32,41 -> max 41
        window(8'd5, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 9, 8'hC0);
        pooled("pool", 8'd41, 1'b0, 1'b0);

        window(8'd5, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 9, 8'h00);
        unpooled("unpool", 8'd14, 8'd23, 8'd32, 8'd41);

        // 9 * 10 * -1 = -90
        window(8'd0, 8'hFF, 8'd10, 8'd10, 8'd10, 8'd10, 9, 8'hC0);
        pooled("relu_neg", 8'd0, 1'b0, 1'b0);
        window(8'd0, 8'hFF, 8'd10, 8'd10, 8'd10, 8'd10, 9, 8'h80);
        pooled("signed_neg", 8'hA6, 1'b0, 1'b0);
        window(8'd0, 8'd1, 8'd200, 8'd200, 8'd200, 8'd200, 9, 8'h80);
        pooled("signed_sat", 8'h7F, 1'b0, 1'b0);

        // 6 + 36 = 42; 42>>2 = 10, rounded 11
`ifdef CONV_MAC_POOL_ROUND_EN
        exp_q = 8'd11;
`else
        exp_q = 8'd10;
`endif
        window(8'd6, 8'd1, 8'd0, 8'd0, 8'd0, 8'd4, 9, 8'h82);
        pooled("shift", exp_q, 1'b0, 1'b0);

        window(8'd5, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 9, 8'hC0);
        pooled("clr", 8'd41, 1'b0, 1'b1);
        window(8'd5, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 9, 8'hC0);
        pooled("after_clr", 8'd41, 1'b0, 1'b0);

        do_reset();
        beat(1'b0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1);
        chk("idle_beat_err", 32'(err), 32'd1);
        chk("idle_beat_valid", 32'(res_valid), 32'd0);
        chk("idle_beat_ready", 32'(in_ready), 32'd1);
        window(8'd5, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 9, 8'hC0);
        pooled("idle_then_win", 8'd41, 1'b1, 1'b0);

        // 5 + 8*4 = 37
        do_reset();
        window(8'd5, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8, 8'hC0);
        pooled("short", 8'd37, 1'b1, 1'b0);

        // restart mid-window: 2 + 9*4 = 38
        do_reset();
        beat(1'b1, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        for (int k = 0; k < 4; k++) begin
            beat(1'b0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1);
        end
        window(8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 9, 8'hC0);
        pooled("restart", 8'd38, 1'b1, 1'b0);

        beat(1'b1, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        for (int k = 0; k < 3; k++) begin
            beat(1'b0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1);
        end
        do_reset();
        chk("rst_acc_valid", 32'(res_valid), 32'd0);
        chk("rst_acc_data", 32'(res_data), 32'd0);
        chk("rst_acc_addr", 32'(res_addr), 32'd0);
        chk("rst_acc_err", 32'(err), 32'd0);
        chk("rst_acc_ready", 32'(in_ready), 32'd1);
        beat(1'b0, 1'b1, 8'hC0, 8'd2, 8'd3, 8'd4, 8'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_acc_quiet%0d", k), 32'(res_valid), 32'd0);
            step();
        end
        chk("rst_acc_cmd_err", 32'(err), 32'd1);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            window(8'd5, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 9, 8'hC0);
            pooled($sformatf("wrap%0d", k), 8'd41, 1'b0, 1'b0);
        end
        chk("wrap_final4", 32'(addr4), 32'd1);
        chk("wrap_final", 32'(res_addr), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
